// File: rtl/riscv_configs_pkg.sv
// rtl/riscv_configs_pkg.sv - shared core configuration: XLEN, control width default, stage buffer state encoding
`ifndef XLEN
`define XLEN 32
`endif

package riscv_configs_pkg;

  localparam int XLEN           = `XLEN;
  localparam int CTRL_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_buf_state_e;

endpackage

// File: rtl/pipeline_perf_cnt.sv
// rtl/pipeline_perf_cnt.sv - stall and bubble cycle counters for a pipeline stage output
module pipeline_perf_cnt (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_ready,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_bubble_cnt
);

  // Free-running wrap-around counters; only reset clears them, flush does not.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stall_cnt  <= 32'd0;
      o_bubble_cnt <= 32'd0;
    end else begin
      if (i_valid && !i_ready) o_stall_cnt <= o_stall_cnt + 32'd1;
      if (!i_valid)            o_bubble_cnt <= o_bubble_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/pipeline_stage_buf.sv
// rtl/pipeline_stage_buf.sv - two-entry skid buffer pipeline stage; PIPE_STAGE_PERF_EN adds stall/bubble counters
`ifndef XLEN
`define XLEN 32
`endif

module pipeline_stage_buf
  import riscv_configs_pkg::*;
#(
  parameter int DATA_W = `XLEN,
  parameter int CTRL_W = CTRL_W_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_bubble_cnt
`endif
);

  stage_buf_state_e  state_q, state_d;
  logic              ready_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic              in_xfer, out_xfer;
  logic              load_main_in, load_main_skid, load_skid_in, clr_main_ctrl;

  assign in_xfer  = i_valid && ready_q;
  assign out_xfer = o_valid && i_ready;
  assign o_ready  = ready_q;
  assign o_valid  = (state_q != ST_EMPTY);
  assign o_ctrl   = main_ctrl_q;
  assign o_data   = main_data_q;

  // Next state and register load selects; flush overrides every transfer.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    clr_main_ctrl  = 1'b0;
    if (i_flush) begin
      state_d       = ST_EMPTY;
      clr_main_ctrl = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d      = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          case ({in_xfer, out_xfer})
            2'b01: begin
              state_d       = ST_EMPTY;
              clr_main_ctrl = 1'b1;
            end
            2'b11: load_main_in = 1'b1;
            2'b10: begin
              state_d      = ST_FULL;
              load_skid_in = 1'b1;
            end
            default: ;
          endcase
        end
        ST_FULL: begin
          if (out_xfer) begin
            state_d        = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          state_d       = ST_EMPTY;
          clr_main_ctrl = 1'b1;
        end
      endcase
    end
  end

  // State register; ready is registered from the next state so it never depends on i_ready.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != ST_FULL);
    end
  end

  // Payload registers; main ctrl is zeroed whenever the stage drains so a bubble never writes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl_q <= i_ctrl;
        main_data_q <= i_data;
      end else if (load_main_skid) begin
        main_ctrl_q <= skid_ctrl_q;
        main_data_q <= skid_data_q;
      end else if (clr_main_ctrl) begin
        main_ctrl_q <= '0;
      end
      if (load_skid_in) begin
        skid_ctrl_q <= i_ctrl;
        skid_data_q <= i_data;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipeline_perf_cnt u_perf_cnt (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (o_valid),
    .i_ready      (i_ready),
    .o_stall_cnt  (o_stall_cnt),
    .o_bubble_cnt (o_bubble_cnt)
  );
`endif

endmodule

// File: doc/pipeline_stage_buf.md
PIPELINE_STAGE_BUF -- requirements
Module: pipeline_stage_buf

Interface
REQ-001 Parameter DATA_W SHALL default to `XLEN (32) and set the datapath payload width in bits.
REQ-002 Parameter CTRL_W SHALL default to 8 and set the control payload width in bits; bit 0 is the register write enable.
REQ-003 Port i_clk SHALL be an input, 1 bit wide: the single clock, with all state updated on its rising edge.
REQ-004 Port i_rst SHALL be an input, 1 bit wide: reset, synchronous and active-high.
REQ-005 Port i_flush SHALL be an input, 1 bit wide: discard all held entries.
REQ-006 Port i_valid SHALL be an input, 1 bit wide: the upstream entry is valid.
REQ-007 Port o_ready SHALL be an output, 1 bit wide: this stage accepts an entry this cycle.
REQ-008 Port i_ctrl SHALL be an input, CTRL_W bits wide: the upstream control payload.
REQ-009 Port i_data SHALL be an input, DATA_W bits wide: the upstream datapath payload.
REQ-010 Port o_valid SHALL be an output, 1 bit wide: the downstream entry is valid.
REQ-011 Port i_ready SHALL be an input, 1 bit wide: downstream accepts the entry.
REQ-012 Port o_ctrl SHALL be an output, CTRL_W bits wide: the downstream control payload.
REQ-013 Port o_data SHALL be an output, DATA_W bits wide: the downstream datapath payload.

Function
REQ-014 The block SHALL be a two-entry skid buffer (main + skid register) with an FSM of states EMPTY, ONE and FULL.
REQ-015 A transfer SHALL occur on a side when valid and ready are both high in the same cycle; the input-to-output latency SHALL be 1 cycle.
REQ-016 o_ready SHALL be driven directly from a register and SHALL equal (state != FULL).
REQ-017 EMPTY SHALL go to ONE on an input transfer and SHALL otherwise stay in EMPTY.
REQ-018 ONE SHALL go to EMPTY on an output transfer with no input, stay in ONE on both transfers or neither, and go to FULL on an input transfer with i_ready low.
REQ-019 FULL SHALL go to ONE on an output transfer, move the skid entry into main, and accept no input.
REQ-020 Entries SHALL leave in arrival order; no entry SHALL be duplicated or dropped, except under flush.
REQ-021 o_valid SHALL equal (state != EMPTY); o_data/o_ctrl SHALL present the main entry.
REQ-022 Whenever o_valid is low, o_ctrl SHALL be all zeros (bubble), so write enable is never seen asserted; o_data SHALL hold its last value.
REQ-023 i_flush SHALL force EMPTY on the next edge, zero o_ctrl and discard any same-cycle input; flush SHALL take priority over every transfer.
REQ-024 When i_valid is low, the i_ctrl/i_data values SHALL NOT be captured.

Reset
REQ-025 When i_rst is high at a rising edge, the state SHALL become EMPTY; o_valid, o_ctrl, o_data and the skid register SHALL become 0, and o_ready SHALL become 1 on the following cycle.
REQ-026 When reset is asserted mid-operation, the block SHALL discard held entries with no partial output, and reset SHALL take priority over flush.

Configuration
REQ-027 With PIPE_STAGE_PERF_EN defined, the block SHALL add 32-bit outputs o_stall_cnt and o_bubble_cnt.
REQ-028 Under PIPE_STAGE_PERF_EN, o_stall_cnt SHALL count cycles with o_valid high and i_ready low; o_bubble_cnt SHALL count cycles with o_valid low.
REQ-029 Under PIPE_STAGE_PERF_EN, both counters SHALL wrap at 2^32, SHALL reset to 0, and SHALL NOT be cleared by flush.
REQ-030 Without PIPE_STAGE_PERF_EN, the ports and counters SHALL be absent, with no other behavioural change.

Structure
REQ-031 The state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) and the CTRL_W default constant SHALL reside in the shared riscv_configs include.
REQ-032 The performance counters SHALL be a single sub-module pipeline_perf_cnt, instantiated only under PIPE_STAGE_PERF_EN; all else SHALL be flat.

Verification
REQ-033 Flow-through: i_ready=1, inputs A=0x11,B=0x22,C=0x33 on consecutive cycles -> o_data shall be A,B,C one cycle later, o_ready constantly 1.
REQ-034 Backpressure: i_ready=0 and 3 inputs offered -> 2 accepted, o_ready=0 from the cycle after the 2nd; then i_ready=1 -> A then B out, no loss.
REQ-035 Flush while FULL with i_valid=1 -> next cycle o_valid=0 and o_ctrl=0x00; the offered entry shall never appear.
REQ-036 Reset mid-stream: i_rst=1 for 1 cycle while FULL -> all outputs 0 next cycle, then o_ready=1, and a new entry 0x55 shall pass with 1-cycle latency.
REQ-037 Bubble: i_valid=0 with i_ctrl=0xFF -> o_ctrl shall stay 0x00.
REQ-038 With PIPE_STAGE_PERF_EN: 5 stall cycles and 3 empty cycles -> o_stall_cnt=5 and o_bubble_cnt=3 (counting from reset).
